md_sched: RTL and testbench

- Iterative multiply/divide sequencer for the 5-stage pipeline. Owns the HI/LO registers.
- Accepts mult/multu/div/divu from the E stage and runs a fixed-latency shift-add or restoring-divide sequence.
- Also accepts mthi/mtlo writes.
- Drives a stall request that the hazard unit ORs into Stall_F, Stall_D and Flush_E while a D-stage instruction needs HI/LO before the sequence finishes.

---
 rtl/md_sched.sv | 156 +++++++++++++++
 tb/tb_md_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Iterative multiply/divide sequencer that owns HI/LO: shift-add multiply,
// restoring divide, sign fix-up in a final cycle, plus mthi/mtlo writes.
module md_sched #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start_E,
  input  logic [1:0]       MdOp_E,
  input  logic [WIDTH-1:0] A_E,
  input  logic [WIDTH-1:0] B_E,
  input  logic             Mthi_E,
  input  logic             Mtlo_E,
  input  logic             MdUse_D,
  output logic             Busy,
  output logic             Done,
  output logic             Stall_MD,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   bop_q, bop_d;
  logic               is_div_q, is_div_d;
  logic               sgn_p_q, sgn_p_d;
  logic               sgn_r_q, sgn_r_d;
  logic               div0_q, div0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_signed = ~MdOp_E[0];
  assign a_mag     = (op_signed && A_E[WIDTH-1]) ? (~A_E + 1'b1) : A_E;
  assign b_mag     = (op_signed && B_E[WIDTH-1]) ? (~B_E + 1'b1) : B_E;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bop_q} : '0);

  // Divide: acc = {remainder, remaining dividend bits / quotient}, shifted left.
  assign div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, bop_q};
  assign div_rem  = div_diff[WIDTH+1] ? acc_q[2*WIDTH-2:WIDTH-1] : div_diff[WIDTH-1:0];

  assign prod_fix = sgn_p_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = div0_q ? '1 : (sgn_p_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
  // Divide by zero leaves |A| in the remainder, so the usual fix-up restores raw A.
  assign rem_fix  = sgn_r_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    bop_d    = bop_q;
    is_div_d = is_div_q;
    sgn_p_d  = sgn_p_q;
    sgn_r_d  = sgn_r_q;
    div0_d   = div0_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (Start_E) begin
          is_div_d = MdOp_E[1];
          sgn_p_d  = op_signed & (A_E[WIDTH-1] ^ B_E[WIDTH-1]);
          sgn_r_d  = op_signed & A_E[WIDTH-1];
          div0_d   = MdOp_E[1] & (B_E == '0);
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          bop_d    = b_mag;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = MdOp_E[1] ? DIV : MUL;
        end else begin
          if (Mthi_E) hi_d = A_E;
          if (Mtlo_E) lo_d = A_E;
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = FIX;
      end
      DIV: begin
        acc_d = {div_rem, acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      bop_q    <= '0;
      is_div_q <= 1'b0;
      sgn_p_q  <= 1'b0;
      sgn_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      bop_q    <= bop_d;
      is_div_q <= is_div_d;
      sgn_p_q  <= sgn_p_d;
      sgn_r_q  <= sgn_r_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Stall_MD = MdUse_D & (busy_q | Start_E);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: latency, results, stall, mthi/mtlo and reset.
module tb_md_sched;
  localparam int W = 32;
  localparam int ITER = W;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         Start_E = 1'b0;
  logic [1:0]   MdOp_E = 2'b00;
  logic [W-1:0] A_E = '0;
  logic [W-1:0] B_E = '0;
  logic         Mthi_E = 1'b0;
  logic         Mtlo_E = 1'b0;
  logic         MdUse_D = 1'b0;
  logic         Busy, Done, Stall_MD;
  logic [W-1:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  md_sched #(.WIDTH(W), .ITER(ITER)) dut (
    .clk(clk), .reset_n(reset_n), .Start_E(Start_E), .MdOp_E(MdOp_E),
    .A_E(A_E), .B_E(B_E), .Mthi_E(Mthi_E), .Mtlo_E(Mtlo_E), .MdUse_D(MdUse_D),
    .Busy(Busy), .Done(Done), .Stall_MD(Stall_MD), .HI(HI), .LO(LO)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || HI !== '0 || LO !== '0 || Stall_MD !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%0b done=%0b hi=%h lo=%h stall=%0b required 0 0 0 0 0",
               Busy, Done, HI, LO, Stall_MD);
    end
    reset_n = 1'b1;
    tick();
  endtask

  // inj: 0 none, 1 Start_E while busy, 2 Mtlo_E while busy, 3 Mthi_E together with Start_E
  task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic use_d, input int inj);
    MdOp_E = op; A_E = a; B_E = b; MdUse_D = use_d; Start_E = 1'b1;
    Mthi_E = (inj == 3);
    #1;
    checks++;
    if (Stall_MD !== use_d) begin
      errors++;
      $display("FAIL %s start_stall got %0b required %0b", nm, Stall_MD, use_d);
    end
    tick();
    for (int c = 0; c <= ITER; c++) begin
      Start_E = (inj == 1 && c == 5);
      Mtlo_E  = (inj == 2 && c == 5);
      Mthi_E  = 1'b0;
      if (c == 5) begin
        MdOp_E = 2'b01; A_E = 32'hDEADBEEF; B_E = 32'h3;
      end
      #1;
      checks++;
      if (Busy !== 1'b1 || Done !== 1'b0 || HI !== m_hi || LO !== m_lo || Stall_MD !== use_d) begin
        errors++;
        $display("FAIL %s cycle%0d busy=%0b done=%0b hi=%h lo=%h stall=%0b required 1 0 %h %h %0b",
                 nm, c, Busy, Done, HI, LO, Stall_MD, m_hi, m_lo, use_d);
      end
      tick();
    end
    Start_E = 1'b0; Mtlo_E = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b1 || HI !== ehi || LO !== elo || Stall_MD !== 1'b0) begin
      errors++;
      $display("FAIL %s result busy=%0b done=%0b hi=%h lo=%h stall=%0b required 0 1 %h %h 0",
               nm, Busy, Done, HI, LO, Stall_MD, ehi, elo);
    end
    m_hi = ehi; m_lo = elo;
    tick();
    checks++;
    if (Done !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
      errors++;
      $display("FAIL %s after_done done=%0b hi=%h lo=%h required 0 %h %h", nm, Done, HI, LO, m_hi, m_lo);
    end
    MdUse_D = 1'b0;
    $display("op %s a=%h b=%h hi=%h lo=%h", nm, a, b, HI, LO);
  endtask

  task automatic test_mul();
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 0);
    run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0);
  endtask

  task automatic test_div();
    run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 0);
    run_op("divu_zero", 2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b0, 0);
    run_op("div_zero",  2'b10, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b0, 0);
    run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 0);
    run_op("div_negb",  2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
  endtask

  task automatic test_busy_ignore();
    run_op("start_busy", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1);
    run_op("mtlo_busy",  2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 2);
  endtask

  task automatic test_mthi_mtlo();
    A_E = 32'h12345678; Mthi_E = 1'b1;
    tick();
    Mthi_E = 1'b0;
    checks++;
    if (HI !== 32'h12345678 || LO !== m_lo) begin
      errors++;
      $display("FAIL mthi hi=%h lo=%h required %h %h", HI, LO, 32'h12345678, m_lo);
    end
    m_hi = 32'h12345678;
    A_E = 32'hCAFEF00D; Mtlo_E = 1'b1;
    tick();
    Mtlo_E = 1'b0;
    checks++;
    if (HI !== m_hi || LO !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL mtlo hi=%h lo=%h required %h %h", HI, LO, m_hi, 32'hCAFEF00D);
    end
    m_lo = 32'hCAFEF00D;
    $display("mthi/mtlo hi=%h lo=%h", HI, LO);
    run_op("start_prio", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1, 3);
  endtask

  task automatic test_async_reset();
    MdOp_E = 2'b10; A_E = 32'd100; B_E = 32'd7; Start_E = 1'b1; MdUse_D = 1'b1;
    tick();
    Start_E = 1'b0;
    repeat (9) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || HI !== '0 || LO !== '0 || Stall_MD !== 1'b0) begin
      errors++;
      $display("FAIL async_reset busy=%0b hi=%h lo=%h stall=%0b required 0 0 0 0", Busy, HI, LO, Stall_MD);
    end
    Start_E = 1'b1;
    #1;
    checks++;
    if (Stall_MD !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_start got %0b required 1", Stall_MD);
    end
    Start_E = 1'b0; MdUse_D = 1'b0;
    m_hi = '0; m_lo = '0;
    $display("reset mid-div busy=%0b hi=%h lo=%h", Busy, HI, LO);
    tick();
    reset_n = 1'b1;
    tick();
    run_op("after_reset", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_busy_ignore();
    test_mthi_mtlo();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
